// File: rtl/selector_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | selector_pipe_if : upstream/downstream handshake bundle for selector_pipe   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface selector_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [WIDTH*NUM_IN-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [7:0]              err_count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err, err_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/selector_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | selector_pipe : N-way operand selector with registered skid-buffered output |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module selector_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  selector_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [7:0] c_ERR_MAX = 8'hFF;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] main_q,      main_d;
  logic [WIDTH-1:0] skid_q,      skid_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q,   sel_err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] w_word;
  logic             w_sel_oor;
  logic             w_in_fire;
  logic             w_out_fire;

  // Out-of-range selects yield an all-zero word but still travel down the pipe.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        w_word = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // When the select width exactly covers NUM_IN no code can be out of range.
  generate
    if (NUM_IN < (1 << SEL_W)) begin : g_oor_chk
      assign w_sel_oor = (int'(bus.in_sel) >= NUM_IN);
    end else begin : g_oor_none
      assign w_sel_oor = 1'b0;
    end
  endgenerate

  assign w_in_fire  = bus.in_valid && in_ready_q;
  assign w_out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    sel_err_d   = sel_err_q;
    err_count_d = err_count_q;

    case (state_q)
      S_EMPTY: begin
        if (w_in_fire) begin
          main_d  = w_word;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          main_d = w_word;
        end else if (w_in_fire) begin
          skid_d  = w_word;
          state_d = S_FULL;
        end else if (w_out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    if (w_in_fire && w_sel_oor) begin
      sel_err_d = 1'b1;
      if (err_count_q != c_ERR_MAX) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    // Handshake flags follow the next occupancy so no path from out_ready reaches in_ready.
    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_selector_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_selector_pipe : directed and randomized checks of selector_pipe          |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_selector_pipe;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  selector_pipe_if #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2)) if_a ();
  selector_pipe_if #(.WIDTH(32), .NUM_IN(3),  .SEL_W(2)) if_b ();
  selector_pipe_if #(.WIDTH(8),  .NUM_IN(2),  .SEL_W(1)) if_c ();
  selector_pipe_if #(.WIDTH(64), .NUM_IN(16), .SEL_W(4)) if_d ();

  selector_pipe #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  selector_pipe #(.WIDTH(32), .NUM_IN(3),  .SEL_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  selector_pipe #(.WIDTH(8),  .NUM_IN(2),  .SEL_W(1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  selector_pipe #(.WIDTH(64), .NUM_IN(16), .SEL_W(4)) u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   a_word [4];
  logic [7:0]    q_c [$];
  logic [63:0]   q_d [$];
  logic [15:0]   dc;
  logic [1023:0] dd;
  int            sc, sd;
  bit            vc, vd, rc, rd, acc_c, acc_d, pop_c, pop_d, drain;
  int            push_n_c, pop_n_c, push_n_d, pop_n_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_word = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    push_n_c = 0; pop_n_c = 0; push_n_d = 0; pop_n_d = 0;

    // Reset with a beat offered on A; it must be ignored.
    rst = 1'b1;
    if_a.in_data = '0; if_a.in_sel = '0; if_a.in_valid = 1'b1; if_a.out_ready = 1'b0;
    if_b.in_data = '0; if_b.in_sel = '0; if_b.in_valid = 1'b0; if_b.out_ready = 1'b0;
    if_c.in_data = '0; if_c.in_sel = '0; if_c.in_valid = 1'b0; if_c.out_ready = 1'b0;
    if_d.in_data = '0; if_d.in_sel = '0; if_d.in_valid = 1'b0; if_d.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_out_data",  64'(if_a.out_data),  64'd0);
    check("rst_in_ready",  64'(if_a.in_ready),  64'd1);
    check("rst_sel_err",   64'(if_b.sel_err),   64'd0);
    check("rst_err_count", 64'(if_b.err_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic select
    if_a.in_data   = {a_word[3], a_word[2], a_word[1], a_word[0]};
    if_a.in_sel    = 2'd2;
    if_a.in_valid  = 1'b1;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    check("basic_data",  64'(if_a.out_data),  64'h33333333);
    check("basic_valid", 64'(if_a.out_valid), 64'd1);

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      if_a.in_sel = 2'(i);
      @(negedge clk);
      check("stream_data",  64'(if_a.out_data),  64'(a_word[i]));
      check("stream_valid", 64'(if_a.out_valid), 64'd1);
      check("stream_ready", 64'(if_a.in_ready),  64'd1);
    end
    if_a.in_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", 64'(if_a.out_valid), 64'd0);

    // Backpressure fills MAIN then SKID
    if_a.out_ready = 1'b0;
    if_a.in_sel    = 2'd1;
    if_a.in_valid  = 1'b1;
    @(negedge clk);
    check("bp_ready_one", 64'(if_a.in_ready), 64'd1);
    check("bp_data_one",  64'(if_a.out_data), 64'h22222222);
    if_a.in_sel = 2'd3;
    @(negedge clk);
    check("bp_ready_full", 64'(if_a.in_ready), 64'd0);
    check("bp_data_full",  64'(if_a.out_data), 64'h22222222);
    if_a.in_sel = 2'd0;
    @(negedge clk);
    check("bp_hold_data",  64'(if_a.out_data),  64'h22222222);
    check("bp_hold_valid", 64'(if_a.out_valid), 64'd1);
    if_a.in_valid  = 1'b0;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    check("bp_second",       64'(if_a.out_data), 64'h44444444);
    check("bp_ready_reopen", 64'(if_a.in_ready), 64'd1);
    @(negedge clk);
    check("bp_empty", 64'(if_a.out_valid), 64'd0);

    // Out-of-range select on the 3-input instance
    if_b.in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    if_b.out_ready = 1'b1;
    if_b.in_sel    = 2'd1;
    if_b.in_valid  = 1'b1;
    @(negedge clk);
    check("oor_legal_data", 64'(if_b.out_data), 64'h22222222);
    check("oor_legal_err",  64'(if_b.sel_err),  64'd0);
    if_b.in_sel = 2'd3;
    @(negedge clk);
    check("oor_data",  64'(if_b.out_data),  64'd0);
    check("oor_valid", 64'(if_b.out_valid), 64'd1);
    check("oor_err",   64'(if_b.sel_err),   64'd1);
    check("oor_count", 64'(if_b.err_count), 64'd1);
    // Refused out-of-range beats must not count
    if_b.out_ready = 1'b0;
    if_b.in_sel    = 2'd1;
    @(negedge clk);
    if_b.in_sel = 2'd3;
    repeat (3) @(negedge clk);
    check("oor_refused_ready", 64'(if_b.in_ready),  64'd0);
    check("oor_refused_count", 64'(if_b.err_count), 64'd1);
    if_b.in_valid  = 1'b0;
    if_b.out_ready = 1'b1;
    @(negedge clk);
    check("oor_skid_data", 64'(if_b.out_data), 64'h22222222);
    @(negedge clk);
    check("oor_drained", 64'(if_b.out_valid), 64'd0);
    if_b.in_sel   = 2'd3;
    if_b.in_valid = 1'b1;
    repeat (253) @(negedge clk);
    check("oor_count_254", 64'(if_b.err_count), 64'd254);
    repeat (47) @(negedge clk);
    check("oor_count_sat", 64'(if_b.err_count), 64'd255);
    check("oor_err_sticky", 64'(if_b.sel_err), 64'd1);
    if_b.in_valid = 1'b0;

    // Asynchronous reset while A is FULL
    if_a.out_ready = 1'b0;
    if_a.in_sel    = 2'd0;
    if_a.in_valid  = 1'b1;
    @(negedge clk);
    if_a.in_sel = 2'd1;
    @(negedge clk);
    if_a.in_valid = 1'b0;
    check("mid_full", 64'(if_a.in_ready), 64'd0);
    #2;
    rst = 1'b1;
    if_a.in_valid = 1'b1;
    #1;
    check("mid_out_valid", 64'(if_a.out_valid), 64'd0);
    check("mid_out_data",  64'(if_a.out_data),  64'd0);
    check("mid_in_ready",  64'(if_a.in_ready),  64'd1);
    check("mid_sel_err",   64'(if_b.sel_err),   64'd0);
    check("mid_err_count", 64'(if_b.err_count), 64'd0);
    @(posedge clk);
    #1;
    check("mid_ignore_in", 64'(if_a.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if_a.in_valid = 1'b0;
    @(negedge clk);
    check("mid_after_valid", 64'(if_a.out_valid), 64'd0);
    check("mid_after_ready", 64'(if_a.in_ready),  64'd1);

    // Randomized sweep on the 2x8 and 16x64 instances against FIFO models
    for (int i = 0; i < 1500; i++) begin
      check("c_in_ready",  64'(if_c.in_ready),  64'(q_c.size() < 2));
      check("c_out_valid", 64'(if_c.out_valid), 64'(q_c.size() != 0));
      if (q_c.size() != 0) check("c_out_data", 64'(if_c.out_data), 64'(q_c[0]));
      check("d_in_ready",  64'(if_d.in_ready),  64'(q_d.size() < 2));
      check("d_out_valid", 64'(if_d.out_valid), 64'(q_d.size() != 0));
      if (q_d.size() != 0) check("d_out_data", if_d.out_data, q_d[0]);

      drain = (i >= 1494);
      dc = 16'($urandom);
      for (int j = 0; j < 32; j++) dd[j*32 +: 32] = $urandom;
      sc = int'($urandom_range(0, 1));
      sd = int'($urandom_range(0, 15));
      vc = !drain && ($urandom_range(0, 3) != 0);
      vd = !drain && ($urandom_range(0, 3) != 0);
      rc = drain || ($urandom_range(0, 2) != 0);
      rd = drain || ($urandom_range(0, 1) != 0);
      if_c.in_data = dc; if_c.in_sel = 1'(sc); if_c.in_valid = vc; if_c.out_ready = rc;
      if_d.in_data = dd; if_d.in_sel = 4'(sd); if_d.in_valid = vd; if_d.out_ready = rd;
      acc_c = vc && (q_c.size() < 2);
      pop_c = rc && (q_c.size() != 0);
      acc_d = vd && (q_d.size() < 2);
      pop_d = rd && (q_d.size() != 0);

      @(posedge clk);
      if (pop_c) begin void'(q_c.pop_front()); pop_n_c++; end
      if (acc_c) begin q_c.push_back(dc[sc*8 +: 8]); push_n_c++; end
      if (pop_d) begin void'(q_d.pop_front()); pop_n_d++; end
      if (acc_d) begin q_d.push_back(dd[sd*64 +: 64]); push_n_d++; end
      @(negedge clk);
    end
    check("c_final_empty", 64'(if_c.out_valid), 64'd0);
    check("d_final_empty", 64'(if_d.out_valid), 64'd0);
    check("c_no_loss", 64'(pop_n_c), 64'(push_n_c));
    check("d_no_loss", 64'(pop_n_d), 64'(push_n_d));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/selector_pipe.md
Name: selector_pipe

Overview:
- Parametrised N-way, W-bit operand selector for the SimpleRisc datapath.
- Generalises the fixed 2:1 32-bit selector to NUM_IN inputs with a binary select.
- Adds a registered output stage with a valid/ready handshake and a 2-entry skid buffer, so it can sit between pipeline stages (e.g. the operand/forwarding select ahead of EX) without breaking timing or throughput.
- Flags out-of-range selects.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH*NUM_IN  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary index of the input to pass.
- in_valid  input  1  upstream offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts this cycle.
- out_data  output  WIDTH  selected word, registered.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts this cycle.
- sel_err  output  1  sticky flag: an accepted in_sel was >= NUM_IN.
- err_count  output  8  number of accepted out-of-range selects; saturates at 255.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Combinational select:
  - word = input[in_sel] when in_sel < NUM_IN.
  - Otherwise word = all zeros, and the beat still transfers (it is not dropped).
- Storage: two entries, MAIN (drives out_data) and SKID.
  - State encoding is EMPTY / ONE / FULL (occupancy 0/1/2).
- Transitions:
  - EMPTY:
    - Input transfer loads MAIN → ONE.
    - out_valid=0.
  - ONE:
    - Input and output transfer together: MAIN reloads, stay ONE.
    - Input only: word goes into SKID → FULL.
    - Output only → EMPTY.
  - FULL:
    - in_ready=0.
    - Output transfer: SKID moves to MAIN → ONE.
- Handshake outputs:
  - in_ready = (state != FULL). It is registered, not derived from out_ready, so there is no combinational ready path.
  - out_valid = (state != EMPTY).
  - out_data = MAIN.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is visible on out_data after edge N.
  - Throughput is 1 beat/cycle while out_ready stays high.
- Ordering and stability:
  - Beats leave strictly in acceptance order; nothing is lost or duplicated.
  - While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
- Error flags:
  - sel_err is set on an accepted out-of-range beat and cleared only by rst.
  - err_count increments on the same event and saturates at 255.
  - A non-accepted beat (in_ready=0) never touches sel_err or err_count.
- Reset:
  - Values after rst: state=EMPTY, out_valid=0, out_data=0, in_ready=1, sel_err=0, err_count=0.
  - Any occupancy is discarded on reset mid-operation, with no partial output.
  - in_ready=1 is asserted during reset; any in_valid presented while rst is high is ignored.
- Simultaneous events: in FULL with out_ready=1, no input is accepted that cycle, because in_ready was already 0.

Test Plan:
- Reset then basic select: NUM_IN=4, WIDTH=32, inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, in_sel=2, in_valid=1, out_ready=1 → one cycle later out_data=0x33333333, out_valid=1.
- Streaming: sels 0,1,2,3 on consecutive cycles with out_ready=1 → out_data is 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, in_ready stays 1.
- Backpressure: out_ready=0, offer sel 1 then sel 3 →
  - in_ready drops after the second accept.
  - out_data holds 0x22222222.
  - Raising out_ready yields 0x22222222 then 0x44444444, then out_valid=0.
- Out-of-range: NUM_IN=3, SEL_W=2, in_sel=3 accepted → out_data=0, sel_err=1, err_count=1. A further 300 such beats leave err_count=255.
- Reset mid-operation: FULL state, assert rst asynchronously between edges → out_valid=0, out_data=0, in_ready=1, and sel_err/err_count cleared immediately, without waiting for a clock edge.
- Parameter sweep: NUM_IN=2, WIDTH=8 and NUM_IN=16, WIDTH=64 with random sel/valid/ready → scoreboard matches input[sel] in order, with zero loss or duplication.
